mem_seq_ctrl: RTL and testbench
===============================

Name: mem_seq_ctrl

Overview:
- Multi-cycle load/store sequencer between the execute stage and the single-port block memory.
- Accepts one RV32 load/store request at a time and translates byte addresses to word addresses.
- Sub-word stores are done as read-modify-write; loads are byte/half extracted and sign/zero extended.
- Returns a one-cycle response pulse with data or an error flag; the pipeline stalls on REQ_READY.

Parameters:
ADDR_W, 5, memory word-address width; the memory holds 2**ADDR_W 32-bit words.

Ports:
CLK  in  1  clock; one clock domain.
RST  in  1  reset; reset is synchronous and active-high.
REQ_VALID  in  1  request present.
REQ_READY  out  1  controller can accept a request.
REQ_WRITE  in  1  1=store, 0=load.
REQ_FUNCT3  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ_ADDR  in  32  byte address (rs1 + imm, already summed).
REQ_WDATA  in  32  store data (rs2); low bits used for sb/sh.
RESP_VALID  out  1  one-cycle response pulse.
RESP_RDATA  out  32  extended load data; 0 for stores and errors.
RESP_ERR  out  1  misaligned, illegal op, or (optionally) out-of-range.
MEM_ADDR  out  ADDR_W  word address to memory.
MEM_WE  out  1  memory write enable.
MEM_WDATA  out  32  memory write data.
MEM_RDATA  in  32  memory read data; valid the cycle after MEM_ADDR is presented with MEM_WE=0.

Behaviour:
- States: IDLE, RD, WR, CAP, RESP.
- REQ_READY=1 only in IDLE and only when RST=0.
- Accept: REQ_VALID&&REQ_READY at edge of cycle 0; op, address and data are registered.
- Word index = REQ_ADDR[ADDR_W+1:2]. Byte lane = REQ_ADDR[1:0].
- Illegal op: load funct3 011/110/111, or store funct3 >=011.
- Misaligned: h/hu with addr[0]=1; w with addr[1:0]!=0.
- Error path: IDLE->RESP; RESP_ERR=1 in cycle 1; no memory access.
- lw/lh/lb/lhu/lbu: IDLE->RD (cycle 1: MEM_ADDR=word, MEM_WE=0) -> CAP (cycle 2: capture extracted and extended MEM_RDATA) -> RESP (cycle 3).
- sw: IDLE->WR (cycle 1: MEM_WE=1, MEM_WDATA=REQ_WDATA) -> RESP (cycle 2).
- sb/sh: IDLE->RD (cycle 1) -> WR (cycle 2) -> RESP (cycle 3).
  - In WR, MEM_WDATA = MEM_RDATA with the addressed lane(s) replaced by REQ_WDATA[7:0] or [15:0].
  - Merge is combinational from MEM_RDATA; MEM_ADDR is held from RD.
- RESP: RESP_VALID=1 for exactly one cycle, then IDLE. No response backpressure.
  - Earliest next accept is the cycle after RESP.
- RESP_RDATA/RESP_ERR are registered, valid only while RESP_VALID=1, and 0 otherwise.
- MEM_WE=1 only in WR; MEM_WDATA=0 outside WR; MEM_ADDR=0 in IDLE.
- Request inputs are ignored while REQ_READY=0.
- Reset:
  - RST at any edge forces IDLE and clears RESP_VALID/RESP_RDATA/RESP_ERR; no response is issued for an aborted request.
  - MEM_WE is gated by !RST combinationally, so a write in progress is suppressed in the reset cycle.
- Upper address bits above ADDR_W+1 are handled per the optional feature.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined: any nonzero bit in REQ_ADDR[31:ADDR_W+2] is an error, taking the error path (RESP in cycle 1, RESP_ERR=1, no memory access). Misalignment and illegal-op checks are unchanged.
- Undefined: upper bits are ignored and the address wraps modulo 2**ADDR_W words.

Test Plan:
- sw 0x0000000C, data 0xDEADBEEF -> cycle1 MEM_WE=1, MEM_ADDR=3, MEM_WDATA=0xDEADBEEF; cycle2 RESP_VALID=1, RESP_ERR=0, RESP_RDATA=0.
- lb 0x0D then lbu 0x0D (word 3 = 0xDEADBEEF) -> cycle3 RESP_RDATA=0xFFFFFFBE, then 0x000000BE; MEM_WE stays 0.
- sh 0x0E, data 0xFFFF1234 -> cycle1 read word 3; cycle2 MEM_WE=1, MEM_WDATA=0x1234BEEF. A following lw 0x0C returns 0x1234BEEF in its cycle3.
- lw 0x0E, then lh 0x0F, then load funct3=011 -> each gives RESP_VALID in cycle1 with RESP_ERR=1, RESP_RDATA=0; MEM_WE never asserted.
- sb 0x0C, data 0x55, with RST=1 during WR -> MEM_WE=0 that cycle, next state IDLE, REQ_READY=1 after RST drops, no RESP_VALID, word 3 unchanged.
- lw 0x00000080 (ADDR_W=5), word 0 = 0xCAFEF00D -> with MEM_BOUNDS_CHECK_EN: cycle1 RESP_ERR=1. Without: cycle3 RESP_RDATA=0xCAFEF00D.

Source files
------------

// File: rtl/mem_seq_ctrl_if.sv
// mem_seq_ctrl_if
// Request/response bus between the execute stage and the load/store sequencer.
//   master : execute stage (drives REQ_*, receives REQ_READY and RESP_*)
//   slave  : mem_seq_ctrl (receives REQ_*, drives REQ_READY and RESP_*)
// Signals:
//   REQ_VALID/REQ_READY  request handshake; the pipeline stalls while REQ_READY=0
//   REQ_WRITE            1=store, 0=load
//   REQ_FUNCT3           RV32 funct3 (b/h/w/bu/hu)
//   REQ_ADDR             byte address
//   REQ_WDATA            store data
//   RESP_VALID           one-cycle response pulse
//   RESP_RDATA           extended load data, 0 for stores and errors
//   RESP_ERR             misaligned, illegal op or out-of-range
interface mem_seq_ctrl_if;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WRITE;
   logic [2:0]  REQ_FUNCT3;
   logic [31:0] REQ_ADDR;
   logic [31:0] REQ_WDATA;
   logic        RESP_VALID;
   logic [31:0] RESP_RDATA;
   logic        RESP_ERR;

   modport master (
      output REQ_VALID, REQ_WRITE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA,
      input  REQ_READY, RESP_VALID, RESP_RDATA, RESP_ERR
   );

   modport slave (
      input  REQ_VALID, REQ_WRITE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA,
      output REQ_READY, RESP_VALID, RESP_RDATA, RESP_ERR
   );
endinterface

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl
// Multi-cycle RV32 load/store sequencer in front of a single-port block memory
// with a one-cycle registered read. One request is in flight at a time.
// Sub-word stores are read-modify-write; sub-word loads are extracted and
// sign/zero extended before the response.
//
// Parameters:
//   ADDR_W     memory word-address width (2**ADDR_W 32-bit words)
// Ports:
//   CLK        clock
//   RST        synchronous active-high reset
//   req        mem_seq_ctrl_if.slave request/response bus
//   MEM_ADDR   word address to memory
//   MEM_WE     memory write enable
//   MEM_WDATA  memory write data
//   MEM_RDATA  memory read data, valid the cycle after a read address
//
// Build option:
//   MEM_BOUNDS_CHECK_EN  when defined, any set bit in REQ_ADDR above the word
//                        index is reported as an error with no memory access;
//                        otherwise the address wraps modulo the memory size.
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request, memory address parked at 0
// RD    | read word presented (loads, and the read half of sb/sh)
// WR    | write cycle (sw direct, sb/sh merged with read data)
// CAP   | load data arrives, extracted/extended into response reg
// RESP  | one-cycle response pulse
module mem_seq_ctrl #(
   parameter int ADDR_W = 5
) (
   input  logic              CLK,
   input  logic              RST,
   mem_seq_ctrl_if.slave     req,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_WE,
   output logic [31:0]       MEM_WDATA,
   input  logic [31:0]       MEM_RDATA
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      CAP  = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              write_q;
   logic [2:0]        funct3_q;
   logic [1:0]        lane_q;
   logic [ADDR_W-1:0] word_q;
   logic [31:0]       wdata_q;
   logic              resp_err_q;
   logic [31:0]       resp_rdata_q;

   logic              accept;
   logic              op_illegal;
   logic              misaligned;
   logic              out_of_range;
   logic              req_err;
   logic [31:0]       rd_shift;
   logic [31:0]       load_data;
   logic [31:0]       merge_data;

   assign req.REQ_READY = (state_q == IDLE) && !RST;
   assign accept        = req.REQ_VALID && req.REQ_READY;

   always_comb begin
      op_illegal = 1'b0;
      if (req.REQ_WRITE)
         op_illegal = (req.REQ_FUNCT3 >= 3'b011);
      else
         op_illegal = (req.REQ_FUNCT3 == 3'b011) || (req.REQ_FUNCT3[2:1] == 2'b11);
      misaligned = ((req.REQ_FUNCT3[1:0] == 2'b01) && req.REQ_ADDR[0]) ||
                   ((req.REQ_FUNCT3[1:0] == 2'b10) && (req.REQ_ADDR[1:0] != 2'b00));
   end

`ifdef MEM_BOUNDS_CHECK_EN
   assign out_of_range = |req.REQ_ADDR[31:ADDR_W+2];
`else
   // Upper bits are dropped so the word index wraps.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req.REQ_ADDR[31:ADDR_W+2];
   assign out_of_range   = 1'b0;
`endif

   assign req_err = op_illegal || misaligned || out_of_range;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_err)
                  state_d = RESP;
               else if (req.REQ_WRITE && (req.REQ_FUNCT3[1:0] == 2'b10))
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD:      state_d = write_q ? WR : CAP;
         WR:      state_d = RESP;
         CAP:     state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         funct3_q     <= 3'b000;
         lane_q       <= 2'b00;
         word_q       <= '0;
         wdata_q      <= '0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         // Response registers only carry a value into RESP and clear after.
         resp_err_q   <= accept && req_err;
         resp_rdata_q <= (state_q == CAP) ? load_data : '0;
         if (accept) begin
            write_q  <= req.REQ_WRITE;
            funct3_q <= req.REQ_FUNCT3;
            lane_q   <= req.REQ_ADDR[1:0];
            word_q   <= req.REQ_ADDR[ADDR_W+1:2];
            wdata_q  <= req.REQ_WDATA;
         end
      end
   end

   // Load extraction: shift the addressed lane down to bit 0, then extend.
   assign rd_shift = MEM_RDATA >> {lane_q, 3'b000};

   always_comb begin
      load_data = MEM_RDATA;
      case (funct3_q)
         3'b000:  load_data = {{24{rd_shift[7]}},  rd_shift[7:0]};
         3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  load_data = {24'd0, rd_shift[7:0]};
         3'b101:  load_data = {16'd0, rd_shift[15:0]};
         default: load_data = MEM_RDATA;
      endcase
   end

   // Store merge: sw bypasses the read entirely, sb/sh patch the word read in RD.
   always_comb begin
      merge_data = MEM_RDATA;
      case (funct3_q[1:0])
         2'b00: begin
            case (lane_q)
               2'd0:    merge_data[7:0]   = wdata_q[7:0];
               2'd1:    merge_data[15:8]  = wdata_q[7:0];
               2'd2:    merge_data[23:16] = wdata_q[7:0];
               default: merge_data[31:24] = wdata_q[7:0];
            endcase
         end
         2'b01: begin
            if (lane_q[1])
               merge_data[31:16] = wdata_q[15:0];
            else
               merge_data[15:0]  = wdata_q[15:0];
         end
         default: merge_data = wdata_q;
      endcase
   end

   assign MEM_ADDR  = (state_q == IDLE) ? '0 : word_q;
   // Reset gates the strobe directly so a write in flight never lands.
   assign MEM_WE    = (state_q == WR) && !RST;
   assign MEM_WDATA = (state_q == WR) ? merge_data : '0;

   assign req.RESP_VALID = (state_q == RESP);
   assign req.RESP_RDATA = resp_rdata_q;
   assign req.RESP_ERR   = resp_err_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
module tb_mem_seq_ctrl;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic              MEM_WE;
   logic [31:0]       MEM_WDATA;
   logic [31:0]       MEM_RDATA = '0;

   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];

   int checks = 0;
   int errors = 0;

   mem_seq_ctrl_if bus ();

   mem_seq_ctrl #(.ADDR_W(ADDR_W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .req       (bus),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_WE    (MEM_WE),
      .MEM_WDATA (MEM_WDATA),
      .MEM_RDATA (MEM_RDATA)
   );

   always #5 CLK = ~CLK;

   // Single-port block memory with registered read.
   always @(posedge CLK) begin
      if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
      MEM_RDATA <= mem[MEM_ADDR];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: response, latency and memory effect of one request,
   // worked out from RV32 load/store rules on a word array.
   task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                        output int lat, output logic do_wr, output int widx,
                        output logic [31:0] new_word);
      int          lane;
      int          size;
      logic        illegal;
      logic        oob;
      logic [31:0] word;
      logic [31:0] m;
      logic [31:0] v;
      widx  = int'((addr >> 2) % DEPTH);
      lane  = int'(addr % 4);
      word  = ref_mem[widx];
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (wr) illegal = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
      else    illegal = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef MEM_BOUNDS_CHECK_EN
      oob = (addr >> (ADDR_W + 2)) != 0;
`else
      oob = 1'b0;
`endif
      err      = illegal || (lane % size != 0) || oob;
      rdata    = '0;
      do_wr    = 1'b0;
      new_word = word;
      m        = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      if (err) begin
         lat = 1;
      end else if (!wr) begin
         lat = 3;
         v   = (word >> (8 * lane)) & m;
         if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~m;
         rdata = v;
      end else begin
         lat      = (size == 4) ? 2 : 3;
         do_wr    = 1'b1;
         m        = m << (8 * lane);
         new_word = (word & ~m) | ((wdata << (8 * lane)) & m);
      end
   endtask

   task automatic run_req(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
      logic        e_err, e_wr;
      logic [31:0] e_rdata, e_word;
      int          e_lat, e_widx;
      logic        got, stray, g_err;
      logic [31:0] g_rdata, we_data, addr1;
      int          g_lat, we_cnt, we_cyc;
      logic [ADDR_W-1:0] we_addr;
      model(wr, f3, addr, wdata, e_err, e_rdata, e_lat, e_wr, e_widx, e_word);
      @(negedge CLK);
      check_val({tag, ".ready"}, {31'd0, bus.REQ_READY}, 32'd1);
      check_val({tag, ".pulse_end"}, {31'd0, bus.RESP_VALID}, 32'd0);
      bus.REQ_VALID  = 1'b1;
      bus.REQ_WRITE  = wr;
      bus.REQ_FUNCT3 = f3;
      bus.REQ_ADDR   = addr;
      bus.REQ_WDATA  = wdata;
      @(posedge CLK);
      #1;
      // Junk on the request bus while busy must be ignored.
      bus.REQ_VALID  = 1'($urandom);
      bus.REQ_WRITE  = 1'($urandom);
      bus.REQ_FUNCT3 = 3'($urandom);
      bus.REQ_ADDR   = $urandom;
      bus.REQ_WDATA  = $urandom;
      got = 1'b0; stray = 1'b0; g_err = 1'b0; g_rdata = '0; g_lat = 0;
      we_cnt = 0; we_cyc = 0; we_addr = '0; we_data = '0; addr1 = '0;
      for (int c = 1; c <= 8 && !got; c++) begin
         @(negedge CLK);
         if (c == 1) addr1 = 32'(MEM_ADDR);
         if (MEM_WE) begin
            we_cnt++; we_cyc = c; we_addr = MEM_ADDR; we_data = MEM_WDATA;
         end
         if (bus.RESP_VALID) begin
            got = 1'b1; g_lat = c; g_rdata = bus.RESP_RDATA; g_err = bus.RESP_ERR;
            bus.REQ_VALID = 1'b0;
         end else if (bus.RESP_RDATA != 0 || bus.RESP_ERR) begin
            stray = 1'b1;
         end
      end
      bus.REQ_VALID = 1'b0;
      check_val({tag, ".latency"}, 32'(g_lat), 32'(e_lat));
      check_val({tag, ".rdata"}, g_rdata, e_rdata);
      check_val({tag, ".err"}, {31'd0, g_err}, {31'd0, e_err});
      check_val({tag, ".stray_resp"}, {31'd0, stray}, 32'd0);
      check_val({tag, ".we_count"}, 32'(we_cnt), e_wr ? 32'd1 : 32'd0);
      if (!e_err) check_val({tag, ".c1_addr"}, addr1, 32'(e_widx));
      if (e_wr) begin
         check_val({tag, ".we_cycle"}, 32'(we_cyc), 32'(e_lat - 1));
         check_val({tag, ".we_addr"}, 32'(we_addr), 32'(e_widx));
         check_val({tag, ".we_data"}, we_data, e_word);
         ref_mem[e_widx] = e_word;
      end
   endtask

   task automatic reset_during_write();
      logic seen;
      @(negedge CLK);
      bus.REQ_VALID  = 1'b1;
      bus.REQ_WRITE  = 1'b1;
      bus.REQ_FUNCT3 = 3'b000;
      bus.REQ_ADDR   = 32'h0000_000C;
      bus.REQ_WDATA  = 32'h0000_0055;
      @(posedge CLK);
      #1 bus.REQ_VALID = 1'b0;
      @(negedge CLK);
      check_val("rst.c1_we", {31'd0, MEM_WE}, 32'd0);
      check_val("rst.c1_addr", 32'(MEM_ADDR), 32'd3);
      @(posedge CLK);
      #1 RST = 1'b1;
      @(negedge CLK);
      check_val("rst.c2_we", {31'd0, MEM_WE}, 32'd0);
      check_val("rst.c2_ready", {31'd0, bus.REQ_READY}, 32'd0);
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check_val("rst.ready_after", {31'd0, bus.REQ_READY}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.RESP_VALID || MEM_WE) seen = 1'b1;
         @(negedge CLK);
      end
      check_val("rst.no_resp", {31'd0, seen}, 32'd0);
      check_val("rst.word3", mem[3], ref_mem[3]);
   endtask

   logic [2:0] legal_f3 [5];

   initial begin
      legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[0]     = 32'hCAFE_F00D;
      ref_mem[0] = 32'hCAFE_F00D;
      bus.REQ_VALID  = 1'b0;
      bus.REQ_WRITE  = 1'b0;
      bus.REQ_FUNCT3 = 3'b000;
      bus.REQ_ADDR   = '0;
      bus.REQ_WDATA  = '0;

      repeat (3) @(negedge CLK);
      check_val("reset.ready", {31'd0, bus.REQ_READY}, 32'd0);
      check_val("reset.resp_valid", {31'd0, bus.RESP_VALID}, 32'd0);
      check_val("reset.we", {31'd0, MEM_WE}, 32'd0);
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check_val("idle.ready", {31'd0, bus.REQ_READY}, 32'd1);
      check_val("idle.mem_addr", 32'(MEM_ADDR), 32'd0);
      check_val("idle.rdata", bus.RESP_RDATA, 32'd0);

      run_req("sw_c",     1'b1, 3'b010, 32'h0000_000C, 32'hDEAD_BEEF);
      run_req("lb_d",     1'b0, 3'b000, 32'h0000_000D, 32'h0);
      run_req("lbu_d",    1'b0, 3'b100, 32'h0000_000D, 32'h0);
      run_req("sh_e",     1'b1, 3'b001, 32'h0000_000E, 32'hFFFF_1234);
      run_req("lw_c",     1'b0, 3'b010, 32'h0000_000C, 32'h0);
      check_val("word3_merged", ref_mem[3], 32'h1234_BEEF);
      run_req("lw_mis",   1'b0, 3'b010, 32'h0000_000E, 32'h0);
      run_req("lh_mis",   1'b0, 3'b001, 32'h0000_000F, 32'h0);
      run_req("ld_ill",   1'b0, 3'b011, 32'h0000_0000, 32'h0);
      run_req("sbu_ill",  1'b1, 3'b100, 32'h0000_0004, 32'h0);
      reset_during_write();
      run_req("lw_hi",    1'b0, 3'b010, 32'h0000_0080, 32'h0);

      for (int n = 0; n < 300; n++) begin
         logic [2:0]  f3;
         logic [31:0] a;
         f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
         a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
         run_req("rand", 1'($urandom), f3, a, $urandom);
      end

      repeat (2) @(negedge CLK);
      for (int i = 0; i < DEPTH; i++) check_val("mem_final", mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
